game_flow_ctrl: RTL and testbench

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_pkg.sv | 22 ++
 rtl/btn_edge.sv | 22 ++
 rtl/game_flow_ctrl.sv | 111 +++++++++++
 tb/tb_game_flow_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state codes, music codes and default timing for the game flow controller
package game_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;
    localparam logic [1:0] MUS_OFF   = 2'd0;
    localparam logic [1:0] MUS_TITLE = 2'd1;
    localparam logic [1:0] MUS_PLAY  = 2'd2;
    localparam logic [1:0] MUS_OVER  = 2'd3;
    localparam int HOLD_TICKS_DEF  = 16;
    localparam int READY_TICKS_DEF = 8;
    function automatic int cnt_w(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction
    function automatic logic [1:0] music_of(input state_t s);
        return s == IDLE ? MUS_TITLE : s == PLAY ? MUS_PLAY : s == OVER ? MUS_OVER : MUS_OFF;
    endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: 2-flop synchronizer plus registered rising-edge pulse for an asynchronous button
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    logic [2:0] sync;
    logic [2:0] vld;
    // vld masks edges until the whole pipeline holds post-reset samples, so a held button never fires
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            vld   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], btn};
            vld   <= {vld[1:0], 1'b1};
            pulse <= sync[1] & ~sync[2] & vld[2];
        end
    end
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: title/countdown/play/pause/game-over sequencer with registered outputs
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int HOLD_TICKS  = HOLD_TICKS_DEF,
    parameter int READY_TICKS = READY_TICKS_DEF
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       endgame,
    input  logic       tick_8hz,
    input  logic       music_en,
    output logic [2:0] state,
    output logic       run_en,
    output logic       score_clr,
    output logic       game_over,
    output logic [1:0] countdown,
    output logic [1:0] music_sel
);
    localparam int CW = cnt_w(READY_TICKS, HOLD_TICKS);
    localparam logic [CW-1:0] RDY_LAST = CW'(READY_TICKS - 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_TICKS);

    logic start_p, pause_p;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, hold_q, hold_d;
    logic [1:0] cd_q, cd_d, mus_d;
    logic clr_d, run_d, over_d;

    btn_edge u_start (.clk(clk_50m), .rst(rst), .btn(start_btn), .pulse(start_p));
    btn_edge u_pause (.clk(clk_50m), .rst(rst), .btn(pause_btn), .pulse(pause_p));

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            cd_q    <= cd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        cd_d    = cd_q;
        clr_d   = 1'b0;
        unique case (state_q)
            IDLE: if (start_p) begin
                state_d = READY;
                cd_d    = 2'd3;
                cnt_d   = '0;
                clr_d   = 1'b1;
            end
            READY: if (tick_8hz) begin
                cnt_d = cnt_q == RDY_LAST ? '0 : cnt_q + 1'b1;
                cd_d  = cnt_q == RDY_LAST ? cd_q - 1'b1 : cd_q;
                state_d = cnt_q == RDY_LAST && cd_q == 2'd1 ? PLAY : READY;
            end
            PLAY: begin
                state_d = endgame ? OVER : pause_p ? PAUSE : PLAY;
                hold_d  = endgame ? '0 : hold_q;
            end
            PAUSE: state_d = pause_p || start_p ? PLAY : PAUSE;
            OVER: if (start_p && hold_q == HOLD_MAX) begin
                state_d = READY;
                cd_d    = 2'd3;
                cnt_d   = '0;
                clr_d   = 1'b1;
            end else if (tick_8hz && hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hold_d  = '0;
                cd_d    = '0;
            end
        endcase
    end

    always_comb begin
        run_d  = state_d == PLAY;
        over_d = state_d == OVER;
        mus_d  = music_en ? music_of(state_d) : MUS_OFF;
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            run_en    <= 1'b0;
            game_over <= 1'b0;
            music_sel <= MUS_OFF;
            score_clr <= 1'b0;
        end else begin
            run_en    <= run_d;
            game_over <= over_d;
            music_sel <= mus_d;
            score_clr <= clr_d;
        end
    end

    assign state     = state_q;
    assign countdown = cd_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed stimulus checked every cycle against a behavioural game-flow model
module tb_game_flow_ctrl;
    localparam int RT = 8;
    localparam int HT = 16;

    logic clk_50m = 1'b0, rst = 1'b1, start_btn = 1'b0, pause_btn = 1'b0;
    logic endgame = 1'b0, tick_8hz = 1'b0, music_en = 1'b0;
    logic [2:0] state;
    logic run_en, score_clr, game_over;
    logic [1:0] countdown, music_sel;

    int checks = 0, errors = 0, clr_cnt = 0;
    bit chk_on = 1'b0;
    int m_state = 0, m_rt = 0, m_hold = 0, since = 0;
    bit m_clr = 1'b0;
    logic [4:0] hs = '0, hp = '0;
    logic [9:0] exp_v = '0;

    game_flow_ctrl #(.HOLD_TICKS(HT), .READY_TICKS(RT)) dut (
        .clk_50m(clk_50m), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
        .endgame(endgame), .tick_8hz(tick_8hz), .music_en(music_en), .state(state),
        .run_en(run_en), .score_clr(score_clr), .game_over(game_over),
        .countdown(countdown), .music_sel(music_sel)
    );

    always #10 clk_50m = ~clk_50m;

    // A press acts on the FSM 4 edges after the pin rises, and only once 5 clean edges follow reset
    always @(posedge clk_50m) begin : model
        bit se, pe;
        int mus;
        hs = {hs[3:0], start_btn};
        hp = {hp[3:0], pause_btn};
        if (rst) begin
            m_state = 0; m_rt = 0; m_hold = 0; m_clr = 0; since = 0;
            exp_v = '0;
        end else begin
            since++;
            se = since >= 5 && hs[3] && !hs[4];
            pe = since >= 5 && hp[3] && !hp[4];
            m_clr = 0;
            case (m_state)
                0: if (se) begin m_state = 1; m_rt = 0; m_clr = 1; end
                1: if (tick_8hz) begin m_rt++; if (m_rt == 3 * RT) m_state = 2; end
                2: if (endgame) begin m_state = 4; m_hold = 0; end else if (pe) m_state = 3;
                3: if (pe || se) m_state = 2;
                4: if (se && m_hold == HT) begin m_state = 1; m_rt = 0; m_clr = 1; end
                   else if (tick_8hz && m_hold < HT) m_hold++;
                default: m_state = 0;
            endcase
            mus = !music_en ? 0 : m_state == 0 ? 1 : m_state == 2 ? 2 : m_state == 4 ? 3 : 0;
            exp_v = {3'(m_state), m_state == 2, m_clr, m_state == 4,
                     2'(m_state == 1 ? 3 - m_rt / RT : 0), 2'(mus)};
        end
    end

    always @(negedge clk_50m) begin
        if (chk_on) begin
            checks++;
            if ({state, run_en, score_clr, game_over, countdown, music_sel} !== exp_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t got=%b exp=%b", $time,
                         {state, run_en, score_clr, game_over, countdown, music_sel}, exp_v);
            end
            if (score_clr === 1'b1) clr_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_8hz = 1'b1; @(negedge clk_50m);
            tick_8hz = 1'b0; @(negedge clk_50m);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1; cyc(6); start_btn = 1'b0; cyc(2);
    endtask

    task automatic press_pause();
        pause_btn = 1'b1; cyc(6); pause_btn = 1'b0; cyc(2);
    endtask

    initial begin
        cyc(1);
        chk_on = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(6);
        chk("reset_state", 32'(state), 0);
        chk("reset_outs", 32'({run_en, score_clr, game_over, countdown, music_sel}), 0);
        music_en = 1'b1; cyc(1);
        chk("idle_music", 32'(music_sel), 1);

        clr_cnt = 0; press_start();
        chk("start_ready", 32'(state), 1);
        chk("start_clr_width", 32'(clr_cnt), 1);
        chk("cd_3", 32'(countdown), 3);
        press_pause(); endgame = 1'b1; cyc(1); endgame = 1'b0;
        chk("ready_ignores", 32'(state), 1);
        ticks(7); chk("cd_3_hold", 32'(countdown), 3);
        ticks(1); chk("cd_2", 32'(countdown), 2);
        ticks(8); chk("cd_1", 32'(countdown), 1);
        ticks(7); chk("tick23_ready", 32'(state), 1);
        ticks(1); chk("tick24_play", 32'(state), 2);
        chk("play_run", 32'(run_en), 1);
        chk("play_music", 32'(music_sel), 2);
        chk("play_cd0", 32'(countdown), 0);

        press_pause(); chk("pause_state", 32'(state), 3);
        chk("pause_run", 32'(run_en), 0);
        ticks(50); endgame = 1'b1; cyc(1); endgame = 1'b0;
        chk("pause_frozen", 32'(state), 3);
        press_pause(); chk("resume_pause", 32'(state), 2);
        press_pause(); press_start(); chk("resume_start", 32'(state), 2);

        pause_btn = 1'b1; cyc(3); endgame = 1'b1; cyc(1); endgame = 1'b0;
        chk("endgame_wins", 32'(state), 4);
        chk("over_flag", 32'(game_over), 1);
        chk("over_music", 32'(music_sel), 3);
        cyc(4); pause_btn = 1'b0; cyc(2);

        ticks(10); press_start(); chk("over_locked", 32'(state), 4);
        ticks(6); clr_cnt = 0; press_start();
        chk("over_restart", 32'(state), 1);
        chk("restart_clr", 32'(clr_cnt), 1);
        chk("restart_cd", 32'(countdown), 3);

        ticks(8); chk("pre_rst_cd2", 32'(countdown), 2);
        start_btn = 1'b1; cyc(2); rst = 1'b1; cyc(1);
        chk("rst_idle", 32'(state), 0);
        chk("rst_cd0", 32'(countdown), 0);
        cyc(1); rst = 1'b0; cyc(10);
        chk("held_start_ignored", 32'(state), 0);
        start_btn = 1'b0; cyc(2);

        music_en = 1'b0; cyc(1);
        chk("mute_idle", 32'(music_sel), 0);
        press_start(); chk("mute_ready", 32'(music_sel), 0);
        ticks(24); chk("mute_play_state", 32'(state), 2);
        chk("mute_play", 32'(music_sel), 0);
        press_pause(); chk("mute_pause", 32'(music_sel), 0);
        press_pause(); endgame = 1'b1; cyc(1); endgame = 1'b0;
        chk("mute_over_state", 32'(state), 4);
        chk("mute_over", 32'(music_sel), 0);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
